// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - AXI4-Lite types and arbiter FSM state encodings
package axi_lite_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [STRB_W-1:0] strb_t;
    typedef logic [1:0]        resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_EXOKAY = 2'b01;
    localparam resp_t RESP_SLVERR = 2'b10;
    localparam resp_t RESP_DECERR = 2'b11;

    // Master-to-slave direction of one AXI4-Lite port
    typedef struct packed {
        addr_t awaddr;
        logic  awvalid;
        data_t wdata;
        strb_t wstrb;
        logic  wvalid;
        logic  bready;
        addr_t araddr;
        logic  arvalid;
        logic  rready;
    } req_t;

    // Slave-to-master direction of one AXI4-Lite port
    typedef struct packed {
        logic  awready;
        logic  wready;
        resp_t bresp;
        logic  bvalid;
        logic  arready;
        data_t rdata;
        resp_t rresp;
        logic  rvalid;
    } rsp_t;

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker: first requester at or after ptr
module rr_arbiter #(
    parameter int N  = 2,
    parameter int MW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [MW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [MW-1:0] idx_o,
    output logic          valid_o
);

    // Search indices >= ptr first, then wrap around to the ones below ptr
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!valid_o && req_i[i] && (MW'(i) >= ptr_i)) begin
                valid_o  = 1'b1;
                gnt_o[i] = 1'b1;
                idx_o    = MW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!valid_o && req_i[i]) begin
                valid_o  = 1'b1;
                gnt_o[i] = 1'b1;
                idx_o    = MW'(i);
            end
        end
    end

endmodule

// File: rtl/axi_lite_arbiter.sv
// rtl/axi_lite_arbiter.sv - N-master to 1-slave AXI4-Lite arbiter, independent RR read/write paths
module axi_lite_arbiter
    import axi_lite_pkg::*;
#(
    parameter int NUM_MASTERS = 2
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  req_t                   m_req [NUM_MASTERS],
    output rsp_t                   m_rsp [NUM_MASTERS],
    output req_t                   s_req,
    input  rsp_t                   s_rsp,
    output logic [NUM_MASTERS-1:0] wr_grant,
    output logic [NUM_MASTERS-1:0] rd_grant
);

    localparam int MW = $clog2(NUM_MASTERS);

    wr_state_t              wr_state_q, wr_state_d;
    rd_state_t              rd_state_q, rd_state_d;
    logic [NUM_MASTERS-1:0] wr_gnt_q, wr_gnt_d, rd_gnt_q, rd_gnt_d;
    logic [MW-1:0]          wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
    logic [MW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                   aw_done_q, aw_done_d, w_done_q, w_done_d;

    logic [NUM_MASTERS-1:0] wr_req_vec, rd_req_vec, wr_win_gnt, rd_win_gnt;
    logic [MW-1:0]          wr_win_idx, rd_win_idx;
    logic                   wr_win_valid, rd_win_valid;
    logic                   aw_hs, w_hs, b_hs, ar_hs, r_hs;

    function automatic logic [MW-1:0] next_idx(input logic [MW-1:0] idx);
        return (idx == MW'(NUM_MASTERS - 1)) ? '0 : idx + MW'(1);
    endfunction

    // Collect per-master write and read requests for the arbiters
    always_comb begin
        wr_req_vec = '0;
        rd_req_vec = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            wr_req_vec[i] = m_req[i].awvalid | m_req[i].wvalid;
            rd_req_vec[i] = m_req[i].arvalid;
        end
    end

    rr_arbiter #(.N(NUM_MASTERS), .MW(MW)) u_wr_arb (
        .req_i  (wr_req_vec),
        .ptr_i  (wr_ptr_q),
        .gnt_o  (wr_win_gnt),
        .idx_o  (wr_win_idx),
        .valid_o(wr_win_valid)
    );

    rr_arbiter #(.N(NUM_MASTERS), .MW(MW)) u_rd_arb (
        .req_i  (rd_req_vec),
        .ptr_i  (rd_ptr_q),
        .gnt_o  (rd_win_gnt),
        .idx_o  (rd_win_idx),
        .valid_o(rd_win_valid)
    );

    // Route the owning master's channels to the slave; everyone else sees zeros
    always_comb begin
        s_req = '0;
        aw_hs = 1'b0;
        w_hs  = 1'b0;
        b_hs  = 1'b0;
        ar_hs = 1'b0;
        r_hs  = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            m_rsp[i] = '0;
        end
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (wr_gnt_q[i] && wr_state_q == W_ADDR) begin
                // A finished channel is masked so the slave never sees a second beat
                s_req.awaddr      = m_req[i].awaddr;
                s_req.awvalid     = m_req[i].awvalid & ~aw_done_q;
                s_req.wdata       = m_req[i].wdata;
                s_req.wstrb       = m_req[i].wstrb;
                s_req.wvalid      = m_req[i].wvalid & ~w_done_q;
                m_rsp[i].awready  = s_rsp.awready & ~aw_done_q;
                m_rsp[i].wready   = s_rsp.wready & ~w_done_q;
                aw_hs             = s_req.awvalid & s_rsp.awready;
                w_hs              = s_req.wvalid & s_rsp.wready;
            end else if (wr_gnt_q[i] && wr_state_q == W_RESP) begin
                s_req.bready      = m_req[i].bready;
                m_rsp[i].bvalid   = s_rsp.bvalid;
                m_rsp[i].bresp    = s_rsp.bresp;
                b_hs              = s_rsp.bvalid & m_req[i].bready;
            end
            if (rd_gnt_q[i] && rd_state_q == R_ADDR) begin
                s_req.araddr      = m_req[i].araddr;
                s_req.arvalid     = m_req[i].arvalid;
                m_rsp[i].arready  = s_rsp.arready;
                ar_hs             = m_req[i].arvalid & s_rsp.arready;
            end else if (rd_gnt_q[i] && rd_state_q == R_DATA) begin
                s_req.rready      = m_req[i].rready;
                m_rsp[i].rvalid   = s_rsp.rvalid;
                m_rsp[i].rdata    = s_rsp.rdata;
                m_rsp[i].rresp    = s_rsp.rresp;
                r_hs              = s_rsp.rvalid & m_req[i].rready;
            end
        end
    end

    // Write path next state: grant only from idle, rotate pointer after the b beat
    always_comb begin
        wr_state_d = wr_state_q;
        wr_gnt_d   = wr_gnt_q;
        wr_idx_d   = wr_idx_q;
        wr_ptr_d   = wr_ptr_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        case (wr_state_q)
            W_IDLE: begin
                if (wr_win_valid) begin
                    wr_state_d = W_ADDR;
                    wr_gnt_d   = wr_win_gnt;
                    wr_idx_d   = wr_win_idx;
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                end
            end
            W_ADDR: begin
                aw_done_d = aw_done_q | aw_hs;
                w_done_d  = w_done_q | w_hs;
                if (aw_done_d && w_done_d) begin
                    wr_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (b_hs) begin
                    wr_state_d = W_IDLE;
                    wr_gnt_d   = '0;
                    wr_ptr_d   = next_idx(wr_idx_q);
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    // Read path next state: same shape as the write path with a single address channel
    always_comb begin
        rd_state_d = rd_state_q;
        rd_gnt_d   = rd_gnt_q;
        rd_idx_d   = rd_idx_q;
        rd_ptr_d   = rd_ptr_q;
        case (rd_state_q)
            R_IDLE: begin
                if (rd_win_valid) begin
                    rd_state_d = R_ADDR;
                    rd_gnt_d   = rd_win_gnt;
                    rd_idx_d   = rd_win_idx;
                end
            end
            R_ADDR: begin
                if (ar_hs) begin
                    rd_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (r_hs) begin
                    rd_state_d = R_IDLE;
                    rd_gnt_d   = '0;
                    rd_ptr_d   = next_idx(rd_idx_q);
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    // State, ownership, pointers and channel-done flags
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_state_q <= W_IDLE;
            rd_state_q <= R_IDLE;
            wr_gnt_q   <= '0;
            rd_gnt_q   <= '0;
            wr_idx_q   <= '0;
            rd_idx_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            wr_gnt_q   <= wr_gnt_d;
            rd_gnt_q   <= rd_gnt_d;
            wr_idx_q   <= wr_idx_d;
            rd_idx_q   <= rd_idx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
        end
    end

    assign wr_grant = wr_gnt_q;
    assign rd_grant = rd_gnt_q;

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// tb/tb_axi_lite_arbiter.sv - directed self-checking bench for axi_lite_arbiter
module tb_axi_lite_arbiter;
    import axi_lite_pkg::*;

    localparam int N = 2;

    logic         aclk = 1'b0;
    logic         areset;
    req_t         m_req [N];
    rsp_t         m_rsp [N];
    req_t         s_req;
    rsp_t         s_rsp;
    logic [N-1:0] wr_grant, rd_grant;

    always #5 aclk = ~aclk;

    axi_lite_arbiter #(.NUM_MASTERS(N)) dut (
        .aclk    (aclk),
        .areset  (areset),
        .m_req   (m_req),
        .m_rsp   (m_rsp),
        .s_req   (s_req),
        .s_rsp   (s_rsp),
        .wr_grant(wr_grant),
        .rd_grant(rd_grant)
    );

    // Slave model: accepts one aw/w pair then answers b; one ar then answers r
    logic  sl_got_aw, sl_got_w, sl_bvalid, sl_rvalid, sl_wready_en;
    addr_t sl_awaddr, sl_araddr;
    data_t sl_wdata, cfg_rdata;
    strb_t sl_wstrb;
    resp_t cfg_bresp, cfg_rresp;
    int    aw_cnt, w_cnt, ar_cnt;

    always_comb begin
        s_rsp         = '0;
        s_rsp.awready = !sl_got_aw && !sl_bvalid;
        s_rsp.wready  = !sl_got_w && !sl_bvalid && sl_wready_en;
        s_rsp.bvalid  = sl_bvalid;
        s_rsp.bresp   = cfg_bresp;
        s_rsp.arready = !sl_rvalid;
        s_rsp.rvalid  = sl_rvalid;
        s_rsp.rdata   = cfg_rdata;
        s_rsp.rresp   = cfg_rresp;
    end

    always @(posedge aclk or posedge areset) begin
        if (areset) begin
            sl_got_aw <= 1'b0; sl_got_w <= 1'b0; sl_bvalid <= 1'b0; sl_rvalid <= 1'b0;
            sl_awaddr <= '0; sl_araddr <= '0; sl_wdata <= '0; sl_wstrb <= '0;
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
        end else begin
            if (s_req.awvalid && s_rsp.awready) begin
                sl_got_aw <= 1'b1; aw_cnt <= aw_cnt + 1; sl_awaddr <= s_req.awaddr;
            end
            if (s_req.wvalid && s_rsp.wready) begin
                sl_got_w <= 1'b1; w_cnt <= w_cnt + 1; sl_wdata <= s_req.wdata; sl_wstrb <= s_req.wstrb;
            end
            if (sl_got_aw && sl_got_w && !sl_bvalid) begin
                sl_bvalid <= 1'b1; sl_got_aw <= 1'b0; sl_got_w <= 1'b0;
            end
            if (sl_bvalid && s_req.bready) sl_bvalid <= 1'b0;
            if (s_req.arvalid && s_rsp.arready) begin
                sl_rvalid <= 1'b1; ar_cnt <= ar_cnt + 1; sl_araddr <= s_req.araddr;
            end
            if (sl_rvalid && s_req.rready) sl_rvalid <= 1'b0;
        end
    end

    int    n_checks = 0;
    int    n_errors = 0;
    resp_t got_bresp [N];
    resp_t got_rresp [N];
    data_t got_rdata [N];
    int    b_cnt [N];
    int    r_cnt [N];
    int    wr_order [$];
    int    base_aw, base_w, base_r1, base_b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: sample handshakes before the edge, master drops valids after it
    task automatic cycle();
        logic [N-1:0] aw_hs, w_hs, b_hs, ar_hs, r_hs;
        resp_t bresp_s [N];
        resp_t rresp_s [N];
        data_t rdata_s [N];
        #1;
        for (int i = 0; i < N; i++) begin
            aw_hs[i]   = m_req[i].awvalid && m_rsp[i].awready;
            w_hs[i]    = m_req[i].wvalid && m_rsp[i].wready;
            b_hs[i]    = m_req[i].bready && m_rsp[i].bvalid;
            ar_hs[i]   = m_req[i].arvalid && m_rsp[i].arready;
            r_hs[i]    = m_req[i].rready && m_rsp[i].rvalid;
            bresp_s[i] = m_rsp[i].bresp;
            rresp_s[i] = m_rsp[i].rresp;
            rdata_s[i] = m_rsp[i].rdata;
        end
        @(posedge aclk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (aw_hs[i]) begin m_req[i].awvalid = 1'b0; wr_order.push_back(i); end
            if (w_hs[i])  m_req[i].wvalid = 1'b0;
            if (b_hs[i])  begin b_cnt[i]++; got_bresp[i] = bresp_s[i]; end
            if (ar_hs[i]) m_req[i].arvalid = 1'b0;
            if (r_hs[i])  begin r_cnt[i]++; got_rresp[i] = rresp_s[i]; got_rdata[i] = rdata_s[i]; end
        end
        @(negedge aclk);
    endtask

    task automatic clear_masters();
        for (int i = 0; i < N; i++) begin
            m_req[i] = '0; b_cnt[i] = 0; r_cnt[i] = 0; got_bresp[i] = '0; got_rresp[i] = '0; got_rdata[i] = '0;
        end
        wr_order.delete();
    endtask

    task automatic do_reset();
        areset = 1'b1;
        clear_masters();
        sl_wready_en = 1'b1;
        @(negedge aclk);
        @(negedge aclk);
        areset = 1'b0;
    endtask

    task automatic wr_req(input int i, input addr_t a, input data_t d, input strb_t s);
        m_req[i].awaddr = a; m_req[i].awvalid = 1'b1;
        m_req[i].wdata  = d; m_req[i].wstrb   = s; m_req[i].wvalid = 1'b1;
        m_req[i].bready = 1'b1;
    endtask

    task automatic rd_req(input int i, input addr_t a, input logic rdy);
        m_req[i].araddr = a; m_req[i].arvalid = 1'b1; m_req[i].rready = rdy;
    endtask

    task automatic wait_b(input int i, input int n, input string tag);
        int k = 0;
        while (b_cnt[i] < n && k < 40) begin cycle(); k++; end
        check(tag, b_cnt[i], n);
    endtask

    task automatic wait_r(input int i, input int n, input string tag);
        int k = 0;
        while (r_cnt[i] < n && k < 40) begin cycle(); k++; end
        check(tag, r_cnt[i], n);
    endtask

    initial begin
        areset = 1'b1;
        cfg_bresp = RESP_OKAY; cfg_rresp = RESP_OKAY; cfg_rdata = '0;
        sl_wready_en = 1'b1;
        clear_masters();
        repeat (2) @(negedge aclk);
        #1;
        check("rst_wr_grant", wr_grant, 0);
        check("rst_rd_grant", rd_grant, 0);
        check("rst_m_rsp0", m_rsp[0], 0);
        check("rst_m_rsp1", m_rsp[1], 0);
        check("rst_s_valids", {s_req.awvalid, s_req.wvalid, s_req.arvalid, s_req.bready, s_req.rready}, 0);
        @(negedge aclk);
        areset = 1'b0;

        // Single write from M0
        wr_req(0, 32'h010, 32'hA5, 4'h1);
        cycle();
        check("t1_grant", wr_grant, 2'b01);
        wait_b(0, 1, "t1_b_done");
        check("t1_aw_cnt", aw_cnt, 1);
        check("t1_w_cnt", w_cnt, 1);
        check("t1_awaddr", sl_awaddr, 32'h010);
        check("t1_wdata", sl_wdata, 32'hA5);
        check("t1_wstrb", sl_wstrb, 4'h1);
        check("t1_bresp", got_bresp[0], RESP_OKAY);
        check("t1_grant_idle", wr_grant, 0);

        // Tie after M0 was served: pointer sits at M1
        wr_order.delete();
        wr_req(0, 32'h100, 32'h11, 4'hF);
        wr_req(1, 32'h104, 32'h22, 4'hF);
        cycle();
        check("t2a_grant", wr_grant, 2'b10);
        check("t2a_m0_awready", m_rsp[0].awready, 1'b0);
        check("t2a_m1_awready", m_rsp[1].awready, 1'b1);
        wait_b(1, 1, "t2a_m1_b");
        wait_b(0, 2, "t2a_m0_b");
        check("t2a_order_n", wr_order.size(), 2);
        check("t2a_first", wr_order[0], 1);
        check("t2a_second", wr_order[1], 0);

        // Tie straight out of reset: M0 first
        do_reset();
        wr_req(0, 32'h200, 32'h33, 4'hF);
        wr_req(1, 32'h204, 32'h44, 4'hF);
        cycle();
        check("t2b_grant", wr_grant, 2'b01);
        wait_b(0, 1, "t2b_m0_b");
        wait_b(1, 1, "t2b_m1_b");
        check("t2b_order_n", wr_order.size(), 2);
        check("t2b_first", wr_order[0], 0);
        check("t2b_second", wr_order[1], 1);

        // Split aw/w: M1 offers w three cycles ahead of aw
        cfg_bresp = RESP_EXOKAY;
        base_aw = aw_cnt; base_w = w_cnt;
        m_req[1].wdata = 32'h77; m_req[1].wstrb = 4'hF; m_req[1].wvalid = 1'b1; m_req[1].bready = 1'b1;
        repeat (3) cycle();
        check("t3_grant", wr_grant, 2'b10);
        check("t3_w_cnt_early", w_cnt - base_w, 1);
        check("t3_aw_cnt_early", aw_cnt - base_aw, 0);
        check("t3_s_wvalid", s_req.wvalid, 1'b0);
        m_req[1].awaddr = 32'h040; m_req[1].awvalid = 1'b1;
        wait_b(1, 2, "t3_b_done");
        check("t3_aw_cnt", aw_cnt - base_aw, 1);
        check("t3_w_cnt", w_cnt - base_w, 1);
        check("t3_awaddr", sl_awaddr, 32'h040);
        check("t3_wdata", sl_wdata, 32'h77);
        check("t3_bresp", got_bresp[1], RESP_EXOKAY);

        // Concurrent read by M0 and write by M1
        cfg_bresp = RESP_OKAY;
        cfg_rdata = 32'h1234_5678;
        base_b0 = b_cnt[0]; base_r1 = r_cnt[1];
        rd_req(0, 32'h020, 1'b1);
        wr_req(1, 32'h030, 32'h33, 4'h3);
        cycle();
        check("t4_wr_grant", wr_grant, 2'b10);
        check("t4_rd_grant", rd_grant, 2'b01);
        wait_r(0, 1, "t4_r_done");
        wait_b(1, 3, "t4_b_done");
        check("t4_rdata_m0", got_rdata[0], 32'h1234_5678);
        check("t4_no_r_m1", r_cnt[1] - base_r1, 0);
        check("t4_no_b_m0", b_cnt[0] - base_b0, 0);
        check("t4_bresp_m1", got_bresp[1], RESP_OKAY);
        check("t4_araddr", sl_araddr, 32'h020);
        check("t4_awaddr", sl_awaddr, 32'h030);

        // Back-pressure on r: slave holds SLVERR data while M0 stalls
        cfg_rdata = 32'h3C;
        cfg_rresp = RESP_SLVERR;
        rd_req(0, 32'h050, 1'b0);
        cycle();
        cycle();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t5_rvalid_%0d", k), m_rsp[0].rvalid, 1'b1);
            check($sformatf("t5_rd_grant_%0d", k), rd_grant, 2'b01);
            cycle();
        end
        m_req[0].rready = 1'b1;
        cycle();
        check("t5_r_cnt", r_cnt[0], 2);
        check("t5_rresp", got_rresp[0], RESP_SLVERR);
        check("t5_rdata", got_rdata[0], 32'h3C);
        check("t5_rd_idle", rd_grant, 0);

        // Reset mid-write: move wr_ptr to M1 first, then stall w after aw
        wr_req(0, 32'h060, 32'h1, 4'h1);
        wait_b(0, 1, "t6_setup_b");
        sl_wready_en = 1'b0;
        wr_req(0, 32'h070, 32'h99, 4'h1);
        cycle();
        cycle();
        check("t6_pre_grant", wr_grant, 2'b01);
        check("t6_pre_awvalid", s_req.awvalid, 1'b0);
        check("t6_pre_wvalid", s_req.wvalid, 1'b1);
        #1;
        areset = 1'b1;
        #1;
        check("t6_rst_grant", wr_grant, 0);
        check("t6_rst_wvalid", s_req.wvalid, 1'b0);
        check("t6_rst_m_rsp0", m_rsp[0], 0);
        clear_masters();
        sl_wready_en = 1'b1;
        @(negedge aclk);
        areset = 1'b0;
        wr_req(0, 32'h080, 32'hAA, 4'hF);
        wr_req(1, 32'h084, 32'hBB, 4'hF);
        wait_b(0, 1, "t6_m0_b");
        wait_b(1, 1, "t6_m1_b");
        check("t6_order_n", wr_order.size(), 2);
        check("t6_first", wr_order[0], 0);
        check("t6_awaddr_last", sl_awaddr, 32'h084);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
